// File: rtl/lynx_tap_loader.sv
// lynx_tap_loader
// Parses a Lynx TAP image arriving byte by byte on the HPS ioctl download
// channel, writes block bodies into system RAM through a ready/valid write
// port, and reports the execution address so the CPU can autostart.
// Several blocks may follow each other within one download.
//
// Optional build macro: LYNX_TAP_CHECKSUM_EN
//   When defined, an 8-bit running sum of each block's data bytes is compared
//   against the block's check byte.
//   A mismatch sends the loader to ERROR, and no completion pulse is given.
//   When undefined, the check byte is consumed and discarded.
//
// Ports
//   clk, reset_n            system clock, synchronous active-low reset
//   ioctl_download/wr/addr/dout  HPS download channel (addr is debug only)
//   ioctl_wait              back-pressure to HPS while a RAM write is pending
//   autostart_basic         allow a completion pulse for BASIC blocks
//   mem_addr/dout/wr/ready  RAM write port, write held until mem_ready
//   tape_complete           one-cycle autostart pulse
//   exec_addr               execution address, valid with tape_complete
//   file_type               type byte of the most recent block
//   block_count             blocks completed this download, saturating at 15
//   busy, error             parser activity, sticky error flag
module lynx_tap_loader #(
  parameter int          ADDR_W     = 16,
  parameter logic [15:0] BASIC_LOAD = 16'h694D
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic              autostart_basic,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic              mem_ready,
  output logic              tape_complete,
  output logic [15:0]       exec_addr,
  output logic [7:0]        file_type,
  output logic [3:0]        block_count,
  output logic              busy,
  output logic              error
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,  S_NAME    = 4'd1,  S_TYPE    = 4'd2,  S_LEN_LO  = 4'd3,
    S_LEN_HI  = 4'd4,  S_LOAD_LO = 4'd5,  S_LOAD_HI = 4'd6,  S_DATA    = 4'd7,
    S_CHECK   = 4'd8,  S_EXEC_LO = 4'd9,  S_EXEC_HI = 4'd10, S_DONE    = 4'd11,
    S_ERROR   = 4'd12
  } state_t;

  localparam logic [7:0]        QUOTE     = 8'h22;
  localparam logic [7:0]        LEADER    = 8'hA5;
  localparam logic [7:0]        T_BASIC   = 8'h42;
  localparam logic [7:0]        T_MCODE   = 8'h4D;
  localparam logic [7:0]        T_DATA    = 8'h44;
  localparam logic [7:0]        T_ASCII   = 8'h41;
  localparam logic [ADDR_W-1:0] BASIC_PTR = ADDR_W'(BASIC_LOAD);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1'b1);

  function automatic logic is_busy(input state_t s);
    case (s)
      S_IDLE, S_DONE, S_ERROR: is_busy = 1'b0;
      default:                 is_busy = 1'b1;
    endcase
  endfunction

  state_t            state_r, state_n;
  logic [7:0]        file_type_r, file_type_n;
  logic [15:0]       len_r, len_n;
  logic [7:0]        lo_r, lo_n;
  logic [ADDR_W-1:0] ptr_r, ptr_n, start_r, start_n, addr_r, addr_n;
  logic [15:0]       exec_r, exec_n;
  logic [3:0]        count_r, count_n;
  logic              error_r, error_n, tc_r, tc_n, wr_r, wr_n;
  logic [7:0]        dout_r, dout_n;
  logic              busy_r, dl_q_r;
  logic              byte_s, take_s, dl_rise_s, dl_fall_s, check_ok_s;
  logic              unused_s;

  assign byte_s    = ioctl_download & ioctl_wr;
  assign dl_rise_s = ioctl_download & ~dl_q_r;
  assign dl_fall_s = ~ioctl_download & dl_q_r;
  // A byte is parsed only when the holding register is free and no download
  // edge or DONE bookkeeping claims this cycle.
  assign take_s    = byte_s & ~wr_r & ~dl_rise_s & (state_r != S_DONE);
  assign unused_s  = ^ioctl_addr;

`ifdef LYNX_TAP_CHECKSUM_EN
  logic [7:0] sum_r;

  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    sum8 = acc + b;
  endfunction

  // Per-block running sum of data bytes, restarted on every type byte
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum_r <= 8'h00;
    end else if (take_s && (state_r == S_TYPE)) begin
      sum_r <= 8'h00;
    end else if (take_s && (state_r == S_DATA)) begin
      sum_r <= sum8(sum_r, ioctl_dout);
    end else begin
      sum_r <= sum_r;
    end
  end

  assign check_ok_s = (ioctl_dout == sum_r);
`else
  assign check_ok_s = 1'b1;
`endif

  // Next-state and next-register values for the parser and write port
  always_comb begin
    state_n     = state_r;
    file_type_n = file_type_r;
    len_n       = len_r;
    lo_n        = lo_r;
    ptr_n       = ptr_r;
    start_n     = start_r;
    addr_n      = addr_r;
    dout_n      = dout_r;
    exec_n      = exec_r;
    count_n     = count_r;
    error_n     = error_r;
    tc_n        = 1'b0;
    if (wr_r && mem_ready) begin
      wr_n = 1'b0;
    end else begin
      wr_n = wr_r;
    end

    if (dl_rise_s) begin
      state_n = S_IDLE;
      error_n = 1'b0;
      count_n = 4'd0;
    end else if (dl_fall_s && busy_r) begin
      state_n = S_ERROR;
      error_n = 1'b1;
    end else if (state_r == S_DONE) begin
      count_n = (count_r == 4'd15) ? 4'd15 : count_r + 4'd1;
      state_n = S_IDLE;
    end else if (byte_s && wr_r) begin
      // Byte arrived while ioctl_wait was asserted: drop it and stop parsing.
      state_n = S_ERROR;
      error_n = 1'b1;
    end else if (take_s) begin
      case (state_r)
        S_IDLE: begin
          if (ioctl_dout == QUOTE) state_n = S_NAME;
          else                     state_n = S_IDLE;
        end
        S_NAME: begin
          if (ioctl_dout == QUOTE) state_n = S_TYPE;
          else                     state_n = S_NAME;
        end
        S_TYPE: begin
          if (ioctl_dout == LEADER) begin
            state_n = S_TYPE;
          end else if ((ioctl_dout == T_BASIC) || (ioctl_dout == T_MCODE) ||
                       (ioctl_dout == T_DATA)  || (ioctl_dout == T_ASCII)) begin
            file_type_n = ioctl_dout;
            state_n     = S_LEN_LO;
          end else begin
            state_n = S_ERROR;
            error_n = 1'b1;
          end
        end
        S_LEN_LO: begin
          len_n[7:0] = ioctl_dout;
          state_n    = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_n[15:8] = ioctl_dout;
          if ((file_type_r == T_MCODE) || (file_type_r == T_DATA)) begin
            state_n = S_LOAD_LO;
          end else begin
            ptr_n   = BASIC_PTR;
            start_n = BASIC_PTR;
            state_n = ({ioctl_dout, len_r[7:0]} == 16'd0) ? S_CHECK : S_DATA;
          end
        end
        S_LOAD_LO: begin
          lo_n    = ioctl_dout;
          state_n = S_LOAD_HI;
        end
        S_LOAD_HI: begin
          ptr_n   = ADDR_W'({ioctl_dout, lo_r});
          start_n = ADDR_W'({ioctl_dout, lo_r});
          state_n = (len_r == 16'd0) ? S_CHECK : S_DATA;
        end
        S_DATA: begin
          addr_n  = ptr_r;
          dout_n  = ioctl_dout;
          wr_n    = 1'b1;
          ptr_n   = ptr_r + PTR_ONE;
          len_n   = len_r - 16'd1;
          state_n = (len_r == 16'd1) ? S_CHECK : S_DATA;
        end
        S_CHECK: begin
          if (!check_ok_s) begin
            state_n = S_ERROR;
            error_n = 1'b1;
          end else begin
            case (file_type_r)
              T_MCODE: state_n = S_EXEC_LO;
              T_BASIC: begin
                exec_n  = BASIC_LOAD;
                tc_n    = autostart_basic;
                state_n = S_DONE;
              end
              default: begin
                exec_n  = 16'(start_r);
                state_n = S_DONE;
              end
            endcase
          end
        end
        S_EXEC_LO: begin
          lo_n    = ioctl_dout;
          state_n = S_EXEC_HI;
        end
        S_EXEC_HI: begin
          exec_n  = {ioctl_dout, lo_r};
          tc_n    = 1'b1;
          state_n = S_DONE;
        end
        default: state_n = state_r;
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Parser state, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      file_type_r <= 8'h00;
      len_r       <= 16'h0000;
      lo_r        <= 8'h00;
      ptr_r       <= '0;
      start_r     <= '0;
      addr_r      <= '0;
      dout_r      <= 8'h00;
      exec_r      <= 16'h0000;
      count_r     <= 4'd0;
      error_r     <= 1'b0;
      tc_r        <= 1'b0;
      wr_r        <= 1'b0;
      busy_r      <= 1'b0;
      dl_q_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      file_type_r <= file_type_n;
      len_r       <= len_n;
      lo_r        <= lo_n;
      ptr_r       <= ptr_n;
      start_r     <= start_n;
      addr_r      <= addr_n;
      dout_r      <= dout_n;
      exec_r      <= exec_n;
      count_r     <= count_n;
      error_r     <= error_n;
      tc_r        <= tc_n;
      wr_r        <= wr_n;
      busy_r      <= is_busy(state_n);
      dl_q_r      <= ioctl_download;
    end
  end

  // ioctl_wait mirrors the pending write: it rises with mem_wr and falls
  // the cycle after the write is accepted.
  assign ioctl_wait    = wr_r;
  assign mem_wr        = wr_r;
  assign mem_addr      = addr_r;
  assign mem_dout      = dout_r;
  assign tape_complete = tc_r;
  assign exec_addr     = exec_r;
  assign file_type     = file_type_r;
  assign block_count   = count_r;
  assign busy          = busy_r;
  assign error         = error_r;

endmodule

// File: tb/tb_lynx_tap_loader.sv
// Self-checking bench for lynx_tap_loader: builds TAP blocks, derives the
// expected RAM writes and autostart events from the block contents, and
// checks the DUT every cycle plus at fixed checkpoints.
module tb_lynx_tap_loader;

  localparam int          AW    = 16;
  localparam logic [15:0] BASIC = 16'h694D;
  localparam logic [7:0]  T_B = 8'h42, T_M = 8'h4D, T_D = 8'h44, T_A = 8'h41;
`ifdef LYNX_TAP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n, ioctl_download, ioctl_wr, autostart_basic, mem_ready;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wait, mem_wr, tape_complete, busy, error;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_dout, file_type;
  logic [15:0]   exec_addr;
  logic [3:0]    block_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] exp_wr[$];
  logic [23:0] wr_log[$];
  logic [15:0] exp_tc[$];
  logic [3:0]  exp_blocks;
  logic        exp_error;
  logic [15:0] exp_exec;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  lynx_tap_loader #(.ADDR_W(AW), .BASIC_LOAD(BASIC)) dut (
    .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .autostart_basic(autostart_basic),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .mem_ready(mem_ready), .tape_complete(tape_complete),
    .exec_addr(exec_addr), .file_type(file_type), .block_count(block_count),
    .busy(busy), .error(error)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle monitor: write port protocol, write contents, autostart pulses
  logic        prev_stall, prev_tc;
  logic [15:0] prev_addr;
  logic [7:0]  prev_dout;
  always @(negedge clk) begin
    if (!reset_n || !mon_en) begin
      prev_stall <= 1'b0;
      prev_tc    <= 1'b0;
    end else begin
      chk("wait_eq_wr", 64'(ioctl_wait), 64'(mem_wr));
      if (prev_stall)
        chk("stall_hold", 64'({mem_wr, mem_addr, mem_dout}), 64'({1'b1, prev_addr, prev_dout}));
      if (mem_wr && mem_ready) begin
        chk("wr_expected", 64'(exp_wr.size() > 0), 64'd1);
        if (exp_wr.size() > 0) chk("wr_addr_data", 64'({mem_addr, mem_dout}), 64'(exp_wr.pop_front()));
        wr_log.push_back({mem_addr, mem_dout});
      end
      if (tape_complete) begin
        chk("tc_expected", 64'(exp_tc.size() > 0), 64'd1);
        if (exp_tc.size() > 0) chk("tc_exec_addr", 64'(exec_addr), 64'(exp_tc.pop_front()));
        chk("tc_single_cycle", 64'(prev_tc), 64'd0);
      end
      prev_stall <= mem_wr && !mem_ready;
      prev_addr  <= mem_addr;
      prev_dout  <= mem_dout;
      prev_tc    <= tape_complete;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(posedge clk); #1;
    while (ioctl_wait && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) chk("wait_timeout", 64'(ioctl_wait), 64'd0);
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    @(posedge clk); #1;
    ioctl_wr   = 1'b0;
  endtask

  task automatic force_byte(input logic [7:0] b);
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    @(posedge clk); #1;
    ioctl_wr   = 1'b0;
  endtask

  task automatic dl_start();
    @(posedge clk); #1;
    ioctl_download = 1'b1;
    @(posedge clk); #1;
    chk("dl_rise_clear", 64'({error, block_count}), 64'd0);
    exp_error  = 1'b0;
    exp_blocks = 4'd0;
  endtask

  task automatic dl_stop();
    @(posedge clk); #1;
    ioctl_download = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic checkpoint(input logic [7:0] typ);
    chk("blk_count", 64'(block_count), 64'(exp_blocks));
    chk("blk_error", 64'(error), 64'(exp_error));
    chk("blk_exec", 64'(exec_addr), 64'(exp_exec));
    chk("blk_type", 64'(file_type), 64'(typ));
    chk("blk_idle", 64'(busy), 64'd0);
  endtask

  // Sends one block and records what the loader must do with it.
  // dat holds data bytes LSB first; only 'cut' of them are sent.
  task automatic send_block(input logic [7:0] typ, input logic [15:0] len,
                            input logic [15:0] load, input logic [31:0] dat,
                            input logic [7:0] chkb, input logic [15:0] ex,
                            input bit auto_b, input int stall_at, input int cut);
    logic [15:0] lp;
    logic [7:0]  sum, d;
    logic        bad, want_tc;
    lp  = (typ == T_B || typ == T_A) ? BASIC : load;
    sum = 8'h00;
    autostart_basic = auto_b;
    send_byte(8'h22); send_byte(8'h4C); send_byte(8'h22);
    send_byte(8'hA5); send_byte(typ);
    send_byte(len[7:0]); send_byte(len[15:8]);
    if (typ == T_M || typ == T_D) begin
      send_byte(load[7:0]); send_byte(load[15:8]);
    end
    for (int i = 0; i < cut; i++) begin
      d = dat[8*i +: 8];
      exp_wr.push_back({lp + 16'(i), d});
      sum = sum + d;
      if (i == stall_at) begin
        @(posedge clk); #1;
        mem_ready = 1'b0;
      end
      send_byte(d);
      chk("wr_follows_byte", 64'(mem_wr), 64'd1);
      if (i == stall_at) begin
        repeat (5) begin @(posedge clk); #1; end
        chk("stall_wr_wait", 64'({mem_wr, ioctl_wait}), 64'd3);
        mem_ready = 1'b1;
      end
    end
    if (cut < int'(len)) return;
    bad = CSUM && (sum != chkb);
    want_tc = !bad && (typ == T_M || (typ == T_B && auto_b));
    if (bad) begin
      exp_error = 1'b1;
    end else begin
      exp_exec   = (typ == T_M) ? ex : lp;
      exp_blocks = (exp_blocks == 4'd15) ? 4'd15 : exp_blocks + 4'd1;
      if (want_tc) exp_tc.push_back(exp_exec);
    end
    send_byte(chkb);
    if (typ == T_M && !bad) begin
      send_byte(ex[7:0]); send_byte(ex[15:8]);
    end
    chk("tc_timing", 64'(tape_complete), 64'(want_tc));
    repeat (2) @(posedge clk);
    #1;
    checkpoint(typ);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = 25'd0;
    ioctl_dout = 8'h00; autostart_basic = 1'b0; mem_ready = 1'b1;
    exp_blocks = 4'd0; exp_error = 1'b0; exp_exec = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({mem_addr, mem_dout, exec_addr, file_type, block_count,
                               tape_complete, mem_wr, ioctl_wait, busy, error}), 64'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Download 1: assorted block types in one image
    dl_start();
    wr_log.delete();
    send_block(T_M, 16'd3, 16'hC000, 32'h00332211, 8'h66, 16'hC010, 1'b0, -1, 3);
    chk("m_exec_lit", 64'(exec_addr), 64'hC010);
    chk("m_count_lit", 64'(block_count), 64'd1);
    chk("m_wr01_lit", 64'({wr_log[0], wr_log[1]}), 64'hC00011_C00122);
    chk("m_wr2_lit", 64'(wr_log[2]), 64'hC00233);

    wr_log.delete();
    send_block(T_B, 16'd2, 16'h0000, 32'h0000BBAA, 8'h65, 16'h0000, 1'b1, -1, 2);
    chk("b_wr_lit", 64'({wr_log[0], wr_log[1]}), 64'h694DAA_694EBB);
    chk("b_exec_lit", 64'(exec_addr), 64'h694D);
    send_block(T_B, 16'd2, 16'h0000, 32'h0000BBAA, 8'h65, 16'h0000, 1'b0, -1, 2);

    wr_log.delete();
    send_block(T_D, 16'd2, 16'hFFFF, 32'h00000201, 8'h03, 16'h0000, 1'b0, -1, 2);
    chk("wrap_wr_lit", 64'({wr_log[0], wr_log[1]}), 64'hFFFF01_000002);

    send_block(T_A, 16'd1, 16'h0000, 32'h00000042, 8'h42, 16'h0000, 1'b0, -1, 1);
    send_block(T_M, 16'd3, 16'h2000, 32'h00C3A55A, 8'hC2, 16'h2000, 1'b0, 1, 3);
    send_block(T_M, 16'd3, 16'hC000, 32'h00332211, 8'h65, 16'hC010, 1'b0, -1, 3);
    chk("csum_err_lit", 64'(error), 64'(CSUM));
    chk("d1_count_lit", 64'(block_count), CSUM ? 64'd6 : 64'd7);
    dl_stop();
    chk("d1_end_error", 64'(error), 64'(exp_error));

    // Download 2: two data blocks, then the download drops mid-body
    dl_start();
    send_block(T_D, 16'd1, 16'h3000, 32'h0000007E, 8'h7E, 16'h0000, 1'b0, -1, 1);
    send_block(T_D, 16'd2, 16'h3100, 32'h0000FF01, 8'h00, 16'h0000, 1'b0, -1, 2);
    chk("two_d_count_lit", 64'(block_count), 64'd2);
    send_block(T_D, 16'd4, 16'h3200, 32'h04030201, 8'h00, 16'h0000, 1'b0, -1, 1);
    chk("busy_mid_data", 64'(busy), 64'd1);
    dl_stop();
    chk("drop_error", 64'({error, busy}), 64'b10);
    chk("drop_count", 64'(block_count), 64'd2);

    // Download 3: unknown type byte
    dl_start();
    send_byte(8'h22); send_byte(8'h22); send_byte(8'h5A);
    chk("bad_type_error", 64'(error), 64'd1);
    dl_stop();

    repeat (3) @(posedge clk);
    #1;
    chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    chk("tc_queue_drained", 64'(exp_tc.size()), 64'd0);

    // Download 4: overrun while a write is stalled, then reset mid-write
    dl_start();
    send_byte(8'h22); send_byte(8'h22); send_byte(T_M);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    mem_ready = 1'b0;
    send_byte(8'h5A);
    force_byte(8'h6B);
    chk("overrun_error", 64'(error), 64'd1);
    chk("overrun_hold", 64'({mem_wr, mem_addr, mem_dout}), 64'h1_4000_5A);
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    @(posedge clk); #1;
    chk("reset_drops_wr", 64'(mem_wr), 64'd0);
    chk("reset_mid_outputs", 64'({mem_addr, mem_dout, exec_addr, file_type, block_count,
                                   tape_complete, ioctl_wait, busy, error}), 64'd0);
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lynx_tap_loader.md
# lynx_tap_loader

Parametrised Lynx TAP image loader: parses the byte stream delivered by the HPS ioctl download channel, writes program bodies into system RAM through a ready/valid write port, and reports the execution address for autostart. It supersedes the single-block loader: multiple blocks per image, configurable address width and BASIC load point, memory back-pressure, and optional checksum verification. It sits between the MiSTer ioctl interface and the RAM arbiter, beside the CPU reset/autostart logic.

## Interface
- ADDR_W, 16: width of mem_addr; load addresses wrap modulo 2^ADDR_W.
- BASIC_LOAD, 16'h694D: load point and exec address for BASIC ('B') blocks.
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  byte strobe; one byte per high cycle.
- ioctl_addr  in  25  image byte offset (debug only, unused in logic).
- ioctl_dout  in  8  image byte.
- ioctl_wait  out  1  back-pressure to HPS; no ioctl_wr may arrive while high.
- autostart_basic  in  1  pulse tape_complete for BASIC blocks.
- mem_addr  out  ADDR_W  RAM write address.
- mem_dout  out  8  RAM write data.
- mem_wr  out  1  write request, held until accepted.
- mem_ready  in  1  write accepted when mem_wr && mem_ready.
- tape_complete  out  1  one-cycle autostart pulse.
- exec_addr  out  16  execution address, valid with tape_complete.
- file_type  out  8  type byte of most recent block.
- block_count  out  4  blocks completed this download, saturating at 15.
- busy  out  1  high in any state except IDLE/DONE/ERROR.
- error  out  1  sticky until next download rising edge or reset.

## Operation
- All state advances only on cycles with ioctl_download && ioctl_wr, except mem handshake and DONE.
- States: IDLE, NAME, TYPE, LEN_LO, LEN_HI, LOAD_LO, LOAD_HI, DATA, CHECK, EXEC_LO, EXEC_HI, DONE, ERROR.
- IDLE: byte 8'h22 -> NAME; other bytes ignored.
- NAME: bytes ignored until 8'h22 -> TYPE.
- TYPE: 8'hA5 ignored (stay); 'B','M','D','A' latched into file_type -> LEN_LO; any other value -> ERROR.
- LEN_LO/LEN_HI: 16-bit little-endian length. 'M','D' -> LOAD_LO; 'B','A' -> load pointer = BASIC_LOAD, -> DATA (or CHECK if length 0).
- LOAD_LO/LOAD_HI: little-endian load pointer (low ADDR_W bits used) -> DATA, or CHECK if length 0.
- DATA: byte captured into single holding register; mem_addr = pointer, mem_dout = byte, mem_wr = 1; pointer +1, remaining length -1. After last byte -> CHECK.
- CHECK: one check byte consumed. 'M' -> EXEC_LO; 'B' -> exec_addr = BASIC_LOAD, DONE; 'D','A' -> exec_addr = last load pointer start, DONE.
- EXEC_LO/EXEC_HI: little-endian exec address -> DONE.
- DONE (one cycle, unconditional): block_count +1; tape_complete = 1 for 'M', and for 'B' only if autostart_basic; never for 'D','A'. -> IDLE (next block may follow in same download).
- ERROR: remains until ioctl_download rising edge; ignores bytes, no writes.
- ioctl_download falling while busy -> ERROR, error = 1.
- ioctl_wr while holding register full (protocol violation): byte dropped, -> ERROR.
- ioctl_download rising edge: error and block_count cleared, state forced to IDLE.

## Timing
- Reset: state IDLE; all outputs 0 (mem_addr, mem_dout, exec_addr, file_type, block_count included).
- mem_wr rises the cycle after the accepting ioctl_wr; ioctl_wait rises in the same cycle as mem_wr and falls the cycle after mem_ready is sampled high with mem_wr.
- With mem_ready tied high: mem_wr is a one-cycle pulse, ioctl_wait a one-cycle pulse, zero sustained stall.
- tape_complete high exactly one cycle, the cycle after the final header/check byte is accepted; exec_addr stable from that cycle until next DONE.
- Reset mid-write drops the pending byte; mem_wr low next cycle.
- Pointer increment wraps 2^ADDR_W-1 -> 0 without error.

## Configuration
- LYNX_TAP_CHECKSUM_EN defined: 8-bit running sum (mod 256) of all DATA bytes per block; CHECK byte mismatch -> ERROR, no DONE, no tape_complete.
- Undefined: CHECK byte consumed and discarded; no checksum logic built.

## Test plan
- 'M' block: "AB" quotes, 'M', len 0003, load C000, data 11 22 33, check 66, exec C010 -> writes C000=11, C001=22, C002=33; tape_complete pulse, exec_addr C010, block_count 1.
- 'B' block len 2, data AA BB, autostart_basic=1 -> writes 694D/694E, tape_complete with exec_addr 694D; repeat with autostart_basic=0 -> no pulse.
- mem_ready low 5 cycles during DATA -> mem_wr and ioctl_wait held 5+ cycles, data/addr stable, no byte lost.
- Two 'D' blocks in one download -> block_count 2, no tape_complete; download drop mid-DATA of third -> error=1.
- With LYNX_TAP_CHECKSUM_EN: check byte 65 for data 11 22 33 -> ERROR, no tape_complete; ADDR_W=16, load FFFF len 2 -> writes FFFF then 0000.
